// File: rtl/sqrt_bcd_display.sv
// Converts an 8-bit binary result to 3 BCD digits with a sequential double-dabble,
// then drives a scanned 3-digit 7-segment display with leading-zero blanking.
module sqrt_bcd_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en
);

    localparam int unsigned     ScanW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e            state_q, state_d;
    logic [19:0]       sr_q, sr_d;
    logic [2:0]        step_q, step_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              bcd_valid_q, bcd_valid_d;
    logic [ScanW-1:0]  scan_q, scan_d;
    logic [2:0]        dig_q, dig_d;

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        step_d      = step_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sr_d    = {12'b0, in_data};
                    step_d  = 3'd0;
                    state_d = StConv;
                end
            end
            StConv: begin
                // Add-3 correction on every BCD nibble, then shift the whole register.
                sr_d   = {adj3(sr_q[18:16]  == 3'd0 ? sr_q[19:16] : sr_q[19:16]),
                          adj3(sr_q[15:12]), adj3(sr_q[11:8]), sr_q[7:0]};
                sr_d   = {sr_d[18:0], 1'b0};
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d       = sr_q[19:8];
                bcd_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scan_d = (scan_q == ScanMax) ? '0 : scan_q + ScanW'(1);
        dig_d  = (scan_q == ScanMax) ? {dig_q[1:0], dig_q[2]} : dig_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            step_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            scan_q      <= '0;
            dig_q       <= 3'b001;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            step_q      <= step_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            scan_q      <= scan_d;
            dig_q       <= dig_d;
        end
    end

    // Tens blanks only when hundreds is also zero; ones is always lit.
    always_comb begin
        seg = 7'h00;
        unique case (dig_q)
            3'b001: seg = seg7(bcd_q[3:0]);
            3'b010: if (bcd_q[11:4] != 8'd0) seg = seg7(bcd_q[7:4]);
            3'b100: if (bcd_q[11:8] != 4'd0) seg = seg7(bcd_q[11:8]);
            default: seg = 7'h00;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign dig_en    = dig_q;

endmodule

// File: tb/tb_sqrt_bcd_display.sv
// Directed bench for sqrt_bcd_display: conversion vectors, handshake timing,
// reset abort, and scan/blanking checks against a small reference model.
module tb_sqrt_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, busy, bcd_valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_en;
    logic        s_in_ready, s_busy, s_bcd_valid;
    logic [11:0] s_bcd;
    logic [6:0]  s_seg;
    logic [2:0]  s_dig_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Edges since the last reset edge; drives the scan model.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    sqrt_bcd_display #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .bcd(bcd), .bcd_valid(bcd_valid),
        .seg(seg), .dig_en(dig_en)
    );

    sqrt_bcd_display dut_slow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .busy(s_busy), .bcd(s_bcd), .bcd_valid(s_bcd_valid),
        .seg(s_seg), .dig_en(s_dig_en)
    );

    typedef struct {
        logic [7:0]  din;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs [10];

    logic [6:0] seg_tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx);
        if (idx == 0) return seg_tbl[b[3:0]];
        if (idx == 1) return (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h00 : seg_tbl[b[7:4]];
        return (b[11:8] == 4'd0) ? 7'h00 : seg_tbl[b[11:8]];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic convert(input logic [7:0] d, input logic [11:0] exp_bcd);
        @(negedge clk);
        chk("ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);              // E0
        #1 in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk("busy_during_conv", {31'b0, busy}, 32'd1);
            chk("no_early_valid", {31'b0, bcd_valid}, 32'd0);
        end
        @(posedge clk);              // E9
        #1;
        chk("bcd_valid_pulse", {31'b0, bcd_valid}, 32'd1);
        chk("bcd_value", {20'b0, bcd}, {20'b0, exp_bcd});
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("ready_after_done", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bcd_valid_one_cycle", {31'b0, bcd_valid}, 32'd0);
        chk("bcd_held", {20'b0, bcd}, {20'b0, exp_bcd});
    endtask

    task automatic scan_check(input logic [11:0] b);
        int idx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idx = (cyc / 4) % 3;
            chk("dig_en_scan", {29'b0, dig_en}, {29'b0, 3'b001 << idx});
            chk("seg_scan", {25'b0, seg}, {25'b0, exp_seg(b, idx)});
        end
    endtask

    initial begin
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd15,  12'h015};
        vecs[2] = '{8'd0,   12'h000};
        vecs[3] = '{8'd9,   12'h009};
        vecs[4] = '{8'd10,  12'h010};
        vecs[5] = '{8'd99,  12'h099};
        vecs[6] = '{8'd100, 12'h100};
        vecs[7] = '{8'd128, 12'h128};
        vecs[8] = '{8'd63,  12'h063};
        vecs[9] = '{8'd201, 12'h201};

        // T1: reset state
        do_reset();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bcd", {20'b0, bcd}, 32'd0);
        chk("rst_bcd_valid", {31'b0, bcd_valid}, 32'd0);
        chk("rst_dig_en", {29'b0, dig_en}, 32'd1);
        chk("rst_seg", {25'b0, seg}, 32'h3F);
        chk("rst_slow_dig_en", {29'b0, s_dig_en}, 32'd1);
        chk("rst_slow_seg", {25'b0, s_seg}, 32'h3F);

        // T2/T3/T6 and others: table-driven conversions with scan/blank checks
        for (int v = 0; v < 10; v++) begin
            convert(vecs[v].din, vecs[v].exp_bcd);
            scan_check(vecs[v].exp_bcd);
        end

        // T4: in_valid held high, data changes mid-conversion
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd42;
        @(posedge clk);              // E0
        #1 in_data = 8'd7;
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("t4_busy_mid", {31'b0, busy}, 32'd1);
            chk("t4_ready_mid", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);              // E9
        #1;
        chk("t4_bcd_42", {20'b0, bcd}, 32'h042);
        chk("t4_pulse_42", {31'b0, bcd_valid}, 32'd1);
        @(posedge clk);              // E10: 7 accepted
        #1 in_valid = 1'b0;
        chk("t4_accept_e10", {31'b0, busy}, 32'd1);
        chk("t4_bcd_hold", {20'b0, bcd}, 32'h042);
        repeat (8) @(posedge clk);   // E11..E18
        #1;
        chk("t4_no_pulse_e18", {31'b0, bcd_valid}, 32'd0);
        @(posedge clk);              // E19
        #1;
        chk("t4_bcd_7", {20'b0, bcd}, 32'h007);
        chk("t4_pulse_7", {31'b0, bcd_valid}, 32'd1);

        // T5: reset at CONV step 4 of 200
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk);              // E0
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);   // E1..E3
        #1 rst = 1'b1;
        @(posedge clk);              // E4 is a reset edge
        #1 rst = 1'b0;
        chk("t5_ready", {31'b0, in_ready}, 32'd1);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_bcd_clr", {20'b0, bcd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_pulse", {31'b0, bcd_valid}, 32'd0);
        end
        convert(8'd100, 12'h100);
        scan_check(12'h100);

        // Default divider: digit must not advance before 1024 clocks, then must.
        for (int i = 0; i < 1100 && cyc < 1030; i++) @(posedge clk);
        @(negedge clk);
        chk("slow_dig_en", {29'b0, s_dig_en}, {29'b0, 3'b001 << ((cyc / 1024) % 3)});
        chk("slow_bcd", {20'b0, s_bcd}, 32'h100);
        chk("slow_seg", {25'b0, s_seg}, {25'b0, exp_seg(12'h100, (cyc / 1024) % 3)});
        chk("fast_dig_en_late", {29'b0, dig_en}, {29'b0, 3'b001 << ((cyc / 4) % 3)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
